// File: rtl/edac_word_seq.sv
// Word sequencer between a core data port and a byte-wide EDAC/RAM pair: each 32-bit access
// becomes four byte passes through the shared EDAC. Also counts corrected and uncorrectable events.

module edac_word_seq #(
  parameter int unsigned AW         = 8,
  parameter logic [31:0] ERROR_CODE = 32'hFFFF_FFFF,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // core side
  input  logic             req_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [31:0]      wdata_i,
  output logic             busy_o,
  output logic             ack_o,
  output logic [31:0]      rdata_o,
  output logic             err_o,
  // event counters
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] corr_cnt_o,
  output logic [CNT_W-1:0] unc_cnt_o,
  // EDAC side
  output logic             edac_en_o,
  output logic             edac_read_o,
  output logic [31:0]      edac_din_o,
  input  logic [31:0]      edac_dout_i,
  // RAM side
  output logic [AW+1:0]    mem_addr_o,
  output logic             mem_we_o,
  output logic             mem_re_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  typedef enum logic [2:0] {
    StIdle,
    StWenc,
    StWmem,
    StRaddr,
    StRdec,
    StRcap,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] corr_q, corr_d;
  logic [CNT_W-1:0] unc_q, unc_d;

  logic [1:0]       corr_inc;
  logic             unc_inc;
  logic [7:0]       rbyte;
  logic [CNT_W:0]   corr_sum;
  logic [CNT_W:0]   unc_sum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      corr_q  <= '0;
      unc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
    end
  end

  // Sequencer: next state, datapath updates and strobes.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    corr_inc    = 2'd0;
    unc_inc     = 1'b0;
    rbyte       = 8'h00;
    ack_o       = 1'b0;
    edac_en_o   = 1'b0;
    edac_read_o = 1'b0;
    edac_din_o  = '0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          idx_d   = 2'd0;
          if (we_i) begin
            state_d = StWenc;
          end else begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = StRaddr;
          end
        end
      end
      StWenc: begin
        edac_en_o  = 1'b1;
        edac_din_o = {24'h0, wdata_q[{idx_q, 3'b000} +: 8]};
        state_d    = StWmem;
      end
      StWmem: begin
        mem_we_o   = 1'b1;
        mem_addr_o = {addr_q, idx_q};
        if (idx_q == 2'd3) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StWenc;
        end
      end
      StRaddr: begin
        mem_re_o   = 1'b1;
        mem_addr_o = {addr_q, idx_q};
        state_d    = StRdec;
      end
      StRdec: begin
        edac_en_o   = 1'b1;
        edac_read_o = 1'b1;
        edac_din_o  = mem_rdata_i;
        state_d     = StRcap;
      end
      StRcap: begin
        // An uncorrectable byte reads as zero; the remaining bytes are still fetched.
        if (edac_dout_i == ERROR_CODE) begin
          rbyte   = 8'h00;
          err_d   = 1'b1;
          unc_inc = 1'b1;
        end else begin
          rbyte    = {edac_dout_i[8:5], edac_dout_i[3:0]};
          corr_inc = {1'b0, edac_dout_i[4]} + {1'b0, edac_dout_i[9]};
        end
        rdata_d[{idx_q, 3'b000} +: 8] = rbyte;
        if (idx_q == 2'd3) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StRaddr;
        end
      end
      StDone: begin
        ack_o   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Saturating counters; the extra sum bit flags overflow, clear wins over increment.
  always_comb begin
    corr_sum = {1'b0, corr_q} + {{(CNT_W - 1){1'b0}}, corr_inc};
    unc_sum  = {1'b0, unc_q} + {{CNT_W{1'b0}}, unc_inc};
    corr_d   = corr_sum[CNT_W] ? CntMax : corr_sum[CNT_W-1:0];
    unc_d    = unc_sum[CNT_W] ? CntMax : unc_sum[CNT_W-1:0];
    if (cnt_clr_i) begin
      corr_d = '0;
      unc_d  = '0;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign corr_cnt_o  = corr_q;
  assign unc_cnt_o   = unc_q;
  assign mem_wdata_o = edac_dout_i;

endmodule

// File: tb/tb_edac_word_seq.sv
// Randomized self-checking bench for edac_word_seq with a triple-copy nibble EDAC model, a RAM
// model and a transaction-level reference model compared against the DUT on every cycle.

module tb_edac_word_seq;

  localparam int unsigned AW    = 8;
  localparam int unsigned CNT_W = 8;
  localparam int          CMAX  = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             req, we, cnt_clr;
  logic [AW-1:0]    addr;
  logic [31:0]      wdata;
  logic             busy, ack, err;
  logic [31:0]      rdata;
  logic [CNT_W-1:0] corr_cnt, unc_cnt;
  logic             edac_en, edac_read;
  logic [31:0]      edac_din, edac_dout;
  logic [AW+1:0]    mem_addr;
  logic             mem_we, mem_re;
  logic [31:0]      mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  edac_word_seq #(
    .AW        (AW),
    .ERROR_CODE(32'hFFFF_FFFF),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .busy_o     (busy),
    .ack_o      (ack),
    .rdata_o    (rdata),
    .err_o      (err),
    .cnt_clr_i  (cnt_clr),
    .corr_cnt_o (corr_cnt),
    .unc_cnt_o  (unc_cnt),
    .edac_en_o  (edac_en),
    .edac_read_o(edac_read),
    .edac_din_o (edac_din),
    .edac_dout_i(edac_dout),
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_re_o   (mem_re),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // EDAC model: each nibble stored three times, majority-decoded; nonzero top byte = uncorrectable.
  function automatic logic [31:0] enc(input logic [7:0] b);
    return {8'h00, {3{b[7:4]}}, {3{b[3:0]}}};
  endfunction

  function automatic logic [3:0] maj(input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [31:0] dec(input logic [31:0] cw);
    logic [3:0] lo, hi;
    logic       fl, fh;
    lo = maj(cw[3:0], cw[7:4], cw[11:8]);
    hi = maj(cw[15:12], cw[19:16], cw[23:20]);
    fl = !((cw[3:0] == cw[7:4]) && (cw[7:4] == cw[11:8]));
    fh = !((cw[15:12] == cw[19:16]) && (cw[19:16] == cw[23:20]));
    if (cw[31:24] != 8'h00) return 32'hFFFF_FFFF;
    return {22'h0, fh, hi, fl, lo};
  endfunction

  // Fault kinds: 1 = low nibble copy flipped, 2 = both nibbles flipped, 3 = uncorrectable.
  function automatic logic [31:0] corrupt(input logic [31:0] w, input int t);
    if (t == 1) return w ^ 32'h0000_0001;
    if (t == 2) return w ^ 32'h0000_1001;
    return w | 32'h8000_0000;
  endfunction

  bit [31:0] ram [0:1023];
  bit        inj_valid;
  int        inj_type;
  int        inj_phys;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (inj_valid) ram[inj_phys] <= corrupt(ram[inj_phys], inj_type);
    if (edac_en) edac_dout <= edac_read ? dec(edac_din) : enc(edac_din[7:0]);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model state (written only by the model process).
  int        m_c = 0;
  int        m_len = 0;
  bit        m_we;
  bit [7:0]  m_addr;
  bit [31:0] m_wdata;
  bit [31:0] m_rdata;
  bit        m_err;
  int        m_corr = 0;
  int        m_unc = 0;
  bit [31:0] ref_word [0:255];
  int        fault [0:1023];
  int        byte_corr [4];
  bit        byte_unc [4];
  int        re_cnt = 0;

  // Model: m_c is the cycle index since acceptance (cycle n follows edge n-1), 0 when idle.
  initial forever begin
    int  k, r, p;
    bit  e_en, e_rd, e_we, e_re, in_read;
    @(negedge clk);
    if (mem_re) re_cnt++;
    if (rst) begin
      m_c = 0; m_rdata = '0; m_err = 1'b0; m_corr = 0; m_unc = 0;
    end else begin
      e_en = 0; e_rd = 0; e_we = 0; e_re = 0;
      in_read = (m_c != 0) && !m_we && (m_c < m_len);
      chk("busy", busy, m_c != 0);
      chk("ack", ack, (m_c != 0) && (m_c == m_len));
      if (m_c != 0 && m_c < m_len) begin
        if (m_we) begin
          if (m_c % 2 == 1) begin
            k = (m_c - 1) / 2; e_en = 1;
            chk("edac_din_wr", edac_din, {24'h0, m_wdata[8*k +: 8]});
          end else begin
            k = (m_c - 2) / 2; e_we = 1;
            chk("mem_addr_wr", mem_addr, {m_addr, k[1:0]});
            chk("mem_wdata", mem_wdata, enc(m_wdata[8*k +: 8]));
          end
        end else begin
          r = (m_c - 1) % 3; k = (m_c - 1) / 3;
          if (r == 0) begin
            e_re = 1;
            chk("mem_addr_rd", mem_addr, {m_addr, k[1:0]});
          end else if (r == 1) begin
            e_en = 1; e_rd = 1;
            chk("edac_din_rd", edac_din, ram[{m_addr, k[1:0]}]);
          end
        end
      end
      chk("edac_en", edac_en, e_en);
      chk("edac_read", edac_read & edac_en, e_rd);
      chk("mem_we", mem_we, e_we);
      chk("mem_re", mem_re, e_re);
      if (!in_read) begin
        chk("rdata", rdata, m_rdata);
        chk("err", err, m_err);
      end
      chk("corr_cnt", corr_cnt, m_corr);
      chk("unc_cnt", unc_cnt, m_unc);

      // Effects of the coming edge.
      if (cnt_clr) begin
        m_corr = 0; m_unc = 0;
      end else if (in_read && (m_c % 3 == 0)) begin
        k = m_c / 3 - 1;
        m_corr = (m_corr + byte_corr[k] > CMAX) ? CMAX : m_corr + byte_corr[k];
        m_unc  = (m_unc + int'(byte_unc[k]) > CMAX) ? CMAX : m_unc + int'(byte_unc[k]);
      end
      if (m_c != 0 && m_we && m_c < m_len && (m_c % 2 == 0)) begin
        k = (m_c - 2) / 2;
        ref_word[m_addr][8*k +: 8] = m_wdata[8*k +: 8];
        fault[{m_addr, k[1:0]}] = 0;
      end
      if (inj_valid) fault[inj_phys] = inj_type;
      if (m_c != 0) begin
        m_c = (m_c == m_len) ? 0 : m_c + 1;
      end else if (req) begin
        m_c = 1; m_we = we; m_addr = addr; m_wdata = wdata; m_len = we ? 9 : 13;
        if (!we) begin
          m_rdata = '0; m_err = 1'b0;
          for (int b = 0; b < 4; b++) begin
            p = {addr, b[1:0]};
            byte_unc[b]  = (fault[p] == 3);
            byte_corr[b] = (fault[p] == 1) ? 1 : (fault[p] == 2) ? 2 : 0;
            if (fault[p] == 3) m_err = 1'b1;
            else m_rdata[8*b +: 8] = ref_word[addr][8*b +: 8];
          end
        end
      end
    end
  end

  bit junk_en = 0;
  bit rand_clr = 0;

  task automatic drive_junk();
    if (junk_en) begin
      req = 1'($urandom); we = 1'($urandom); addr = 8'($urandom); wdata = $urandom;
    end
    if (rand_clr) cnt_clr = ($urandom % 16 == 0);
  endtask

  // Called in cycle 1 (just after the accepting edge); returns the ack cycle.
  task automatic wait_ack(output int lat);
    lat = 1;
    while (!ack && lat < 40) begin
      @(posedge clk); #2;
      lat++;
      drive_junk();
    end
    if (!ack) begin
      n_chk++;
      $display("FAIL ack_timeout: no ack after %0d cycles, expected within 13", lat);
    end
    req = 1'b0;
    @(posedge clk); #2;
    if (rand_clr) cnt_clr = ($urandom % 16 == 0);
  endtask

  task automatic do_txn(input bit w, input logic [7:0] a, input logic [31:0] d);
    int lat;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #2;
    req = 1'b0;
    drive_junk();
    wait_ack(lat);
    chk(w ? "write_latency" : "read_latency", lat, w ? 9 : 13);
  endtask

  task automatic inject(input int phys, input int t);
    inj_phys = phys; inj_type = t; inj_valid = 1'b1;
    @(posedge clk); #2;
    inj_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int re0, lat;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; cnt_clr = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_corr", corr_cnt, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    // Directed write and clean read-back.
    do_txn(1'b1, 8'd3, 32'hA5C3_0F12);
    chk("cw_byte0", ram[12], 32'h0011_1222);
    chk("cw_byte1", ram[13], 32'h0000_0FFF);
    chk("cw_byte2", ram[14], 32'h00CC_C333);
    chk("cw_byte3", ram[15], 32'h00AA_A555);
    do_txn(1'b0, 8'd3, 32'h0);
    chk("clean_rdata", rdata, 32'hA5C3_0F12);
    chk("clean_corr", corr_cnt, 0);

    // Single-bit flip is corrected.
    inject(13, 1);
    do_txn(1'b0, 8'd3, 32'h0);
    chk("corr_rdata", rdata, 32'hA5C3_0F12);
    chk("corr_err", err, 0);
    chk("corr_cnt_1", corr_cnt, 1);

    // Uncorrectable byte 2; all four fetches still happen.
    inject(14, 3);
    re0 = re_cnt;
    do_txn(1'b0, 8'd3, 32'h0);
    chk("unc_rdata", rdata, 32'hA500_0F12);
    chk("unc_err", err, 1);
    chk("unc_cnt_1", unc_cnt, 1);
    chk("unc_re_pulses", re_cnt - re0, 4);

    // Reset during the third memory write leaves a partial word.
    do_txn(1'b1, 8'd9, 32'h1122_3344);
    req = 1'b1; we = 1'b1; addr = 8'd9; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    req = 1'b0;
    repeat (5) begin @(posedge clk); #2; end
    chk("abort_pre_we", mem_we, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    chk("abort_strobes", {edac_en, edac_read, mem_we, mem_re}, 0);
    chk("abort_edac_din", edac_din, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_err", err, 0);
    chk("abort_cnts", {corr_cnt, unc_cnt}, 0);
    @(posedge clk); #2;
    rst = 1'b0; req = 1'b1; we = 1'b0; addr = 8'd9;
    @(posedge clk); #1;
    chk("accept_after_reset", busy, 1);
    #1;
    req = 1'b0;
    wait_ack(lat);
    chk("abort_read_latency", lat, 13);
    chk("partial_word", rdata, 32'h1122_BEEF);

    // Drive corr_cnt to FE, then saturate.
    cnt_clr = 1'b1;
    @(posedge clk); #2;
    cnt_clr = 1'b0;
    do_txn(1'b1, 8'd4, 32'h5A5A_5A5A);
    for (int b = 0; b < 4; b++) inject(16 + b, 2);
    do_txn(1'b1, 8'd5, 32'h0123_4567);
    for (int b = 0; b < 3; b++) inject(20 + b, 2);
    do_txn(1'b1, 8'd6, 32'h89AB_CDEF);
    inject(24, 2);
    for (int n = 0; n < 31; n++) do_txn(1'b0, 8'd4, 32'h0);
    do_txn(1'b0, 8'd5, 32'h0);
    chk("corr_fe", corr_cnt, 8'hFE);
    do_txn(1'b0, 8'd6, 32'h0);
    chk("corr_sat", corr_cnt, 8'hFF);
    chk("sat_rdata", rdata, 32'h89AB_CDEF);

    // Clear held across increments wins.
    inject(25, 3);
    cnt_clr = 1'b1;
    do_txn(1'b0, 8'd6, 32'h0);
    cnt_clr = 1'b0;
    chk("clr_corr", corr_cnt, 0);
    chk("clr_unc", unc_cnt, 0);
    chk("clr_err", err, 1);

    // Randomized traffic with random faults, junk requests and counter clears.
    junk_en = 1; rand_clr = 1;
    for (int n = 0; n < 60; n++) begin
      int pa;
      do_txn(1'($urandom), 8'($urandom % 8), $urandom);
      if ($urandom % 3 == 0) begin
        pa = int'($urandom % 32);
        if (fault[pa] == 0) inject(pa, 1 + int'($urandom % 3));
      end
      repeat ($urandom % 3) begin @(posedge clk); #2; drive_junk(); req = 1'b0; end
    end
    junk_en = 0; rand_clr = 0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
